regfile_wdec_clr: RTL

- Parametrised register file with an integrated one-hot write-address decoder, two asynchronous read ports and a sequential bulk-clear engine.
- Generalises the 4-to-16 write decoder to 2**ADDR_W registers of DATA_W bits each.
- Adds storage, read bypass, an optional hardwired zero register, and a multi-cycle clear FSM with a busy/drop indication.
- Sits between the datapath write-back stage and the ALU operand muxes.

---
 rtl/regfile_wdec_clr_pkg.sv | 19 +
 rtl/regfile_wdec_clr_if.sv | 38 +++
 rtl/regfile_wdec_clr_wdec_onehot.sv | 25 ++
 rtl/regfile_wdec_clr.sv | 131 +++++++++++++
 4 files changed

// File: rtl/regfile_wdec_clr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared FSM state type and sizing helper for regfile_wdec_clr.
// Revision : 1.0
// ============================================================================
package rf_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wdec_clr_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wdec_clr_if
// Brief    : Write/read/clear bus between write-back, ALU muxes and the regfile.
// Revision : 1.0
// ============================================================================
interface regfile_wdec_clr_if
  import rf_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  localparam int NREGS = nregs(ADDR_W);

  logic              wr;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              clr;
  logic [ADDR_W-1:0] ra_a;
  logic [ADDR_W-1:0] ra_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [NREGS-1:0]  wen;
  logic              busy;
  logic              wr_drop;

  modport master (
    output wr, wa, wd, clr, ra_a, ra_b,
    input  rd_a, rd_b, wen, busy, wr_drop
  );

  modport slave (
    input  wr, wa, wd, clr, ra_a, ra_b,
    output rd_a, rd_b, wen, busy, wr_drop
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wdec_clr_wdec_onehot.sv
`default_nettype none
// ============================================================================
// Module   : wdec_onehot
// Brief    : ADDR_W to 2**ADDR_W one-hot decoder with enable.
// Revision : 1.0
// ============================================================================
module wdec_onehot
  import rf_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                    en,
  input  logic [ADDR_W-1:0]       addr,
  output logic [nregs(ADDR_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wdec_clr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wdec_clr
// Brief    : 2**ADDR_W x DATA_W register file, one-hot write decode, two async
//            read ports with optional write-through, and a sequential clear.
// Revision : 1.0
// ============================================================================
module regfile_wdec_clr
  import rf_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               resetn,
  regfile_wdec_clr_if.slave  bus
);

  localparam int              NREGS  = nregs(ADDR_W);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(NREGS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_wr_drop;
  logic              w_idle;
  logic [NREGS-1:0]  w_wen_raw;
  logic [NREGS-1:0]  w_wen;
  logic [DATA_W-1:0] w_rf [NREGS];

  assign w_idle = (r_state == IDLE);

  // Writes are only decoded while idle; the clear engine owns the array otherwise.
  wdec_onehot #(
    .ADDR_W (ADDR_W)
  ) u_wdec (
    .en     (bus.wr && w_idle),
    .addr   (bus.wa),
    .onehot (w_wen_raw)
  );

  always_comb begin
    w_wen = w_wen_raw;
    if (ZERO_REG != 0) begin
      w_wen[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_drop <= bus.wr && !w_idle;
    end
  end

  // The counter is ADDR_W bits, so stepping past the last index wraps to 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.clr) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == C_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [ADDR_W-1:0] C_IDX = ADDR_W'(i);
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign w_rf[i] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_q <= '0;
        end else if (!w_idle && (r_cnt == C_IDX)) begin
          r_q <= '0;
        end else if (w_wen[i]) begin
          r_q <= bus.wd;
        end
      end
      assign w_rf[i] = r_q;
    end
  end

  // w_wen is all-zero during a clear, which also disables the write-through path.
  always_comb begin
    bus.rd_a = w_rf[bus.ra_a];
    if ((ZERO_REG != 0) && (bus.ra_a == '0)) begin
      bus.rd_a = '0;
    end else if ((BYPASS != 0) && w_wen[bus.ra_a]) begin
      bus.rd_a = bus.wd;
    end
  end

  always_comb begin
    bus.rd_b = w_rf[bus.ra_b];
    if ((ZERO_REG != 0) && (bus.ra_b == '0)) begin
      bus.rd_b = '0;
    end else if ((BYPASS != 0) && w_wen[bus.ra_b]) begin
      bus.rd_b = bus.wd;
    end
  end

  assign bus.wen     = w_wen;
  assign bus.busy    = !w_idle;
  assign bus.wr_drop = r_wr_drop;

endmodule
`default_nettype wire
